// File: rtl/ifu_axi_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and AXI4-Lite constants.
package ifu_axi_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0]  AXI_ARPROT_INST = 3'b100;
  localparam logic [31:0] INST_NOP        = 32'h00000013;

endpackage

// File: rtl/ifu_axi_fetch.sv
// Blocking instruction fetch: one PC in, one AXI4-Lite read out, one {inst, pc, fault} to decode.
// All outputs are registers; a single outstanding transaction at a time.
module ifu_axi_fetch
  import ifu_axi_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] FAULT_INST = DATA_W'(INST_NOP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  ifu_state_e        state_q;
  logic              pc_ready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              inst_valid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_fault_q;

  // Control and data registers share one FSM block so every output is registered
  // and changes in lockstep with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_ready_q   <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      araddr_q     <= '0;
      inst_q       <= FAULT_INST;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_valid && pc_ready_q) begin
            araddr_q   <= fetch_pc;
            inst_pc_q  <= fetch_pc;
            pc_ready_q <= 1'b0;
            // A misaligned PC never reaches memory; the fault goes straight to decode.
            if (fetch_pc[1:0] != 2'b00) begin
              inst_q       <= FAULT_INST;
              inst_fault_q <= 1'b1;
              inst_valid_q <= 1'b1;
              state_q      <= OUT;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ADDR;
            end
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b1;
            state_q      <= OUT;
            if (rresp != AXI_RESP_OKAY) begin
              inst_q       <= FAULT_INST;
              inst_fault_q <= 1'b1;
            end else begin
              inst_q       <= rdata;
              inst_fault_q <= 1'b0;
            end
          end
        end
        OUT: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            pc_ready_q   <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          pc_ready_q   <= 1'b1;
          arvalid_q    <= 1'b0;
          rready_q     <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_ready   = pc_ready_q;
  assign araddr     = araddr_q;
  assign arprot     = AXI_ARPROT_INST;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch; the memory side is driven by hand step by step.
module tb_ifu_axi_fetch;

  logic        clk;
  logic        rst_n;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] fetch_pc;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int total;
  int bad;

  ifu_axi_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .fetch_pc   (fetch_pc),
    .araddr     (araddr),
    .arprot     (arprot),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic arr,
                               input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                               input logic ir);
    pc_valid   = pv;
    fetch_pc   = pc;
    arready    = arr;
    rvalid     = rv;
    rdata      = rd;
    rresp      = rr;
    inst_ready = ir;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " pc_ready"}, 32'(pc_ready), 32'd1);
    checkOutput({tag, " arvalid"}, 32'(arvalid), 32'd0);
    checkOutput({tag, " rready"}, 32'(rready), 32'd0);
    checkOutput({tag, " inst_valid"}, 32'(inst_valid), 32'd0);
    checkOutput({tag, " araddr"}, araddr, 32'h0);
    checkOutput({tag, " inst"}, inst, 32'h00000013);
    checkOutput({tag, " inst_pc"}, inst_pc, 32'h0);
    checkOutput({tag, " inst_fault"}, 32'(inst_fault), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    step();
    checkReset("reset");
    checkOutput("arprot", 32'(arprot), 32'h4);
    rst_n = 1'b1;

    $display("[TB] zero-wait fetch");
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    checkOutput("t1 arvalid@1", 32'(arvalid), 32'd1);
    checkOutput("t1 araddr", araddr, 32'h8000_0000);
    checkOutput("t1 pc_ready", 32'(pc_ready), 32'd0);
    pc_valid = 1'b0;
    step();
    checkOutput("t1 arvalid drop", 32'(arvalid), 32'd0);
    checkOutput("t1 rready", 32'(rready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0010_0093, 2'b00, 1'b0);
    step();
    checkOutput("t1 inst_valid@3", 32'(inst_valid), 32'd1);
    checkOutput("t1 inst", inst, 32'h0010_0093);
    checkOutput("t1 inst_pc", inst_pc, 32'h8000_0000);
    checkOutput("t1 fault", 32'(inst_fault), 32'd0);
    checkOutput("t1 rready drop", 32'(rready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    step();
    checkOutput("t1 accepted", 32'(inst_valid), 32'd0);
    checkOutput("t1 pc_ready back", 32'(pc_ready), 32'd1);

    $display("[TB] AR back-pressure");
    applyStimulus(1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("t2 arvalid hold %0d", i), 32'(arvalid), 32'd1);
      checkOutput($sformatf("t2 araddr hold %0d", i), araddr, 32'h8000_0004);
      checkOutput($sformatf("t2 pc_ready %0d", i), 32'(pc_ready), 32'd0);
      checkOutput($sformatf("t2 rready %0d", i), 32'(rready), 32'd0);
    end
    arready = 1'b1;
    step();
    checkOutput("t2 rready", 32'(rready), 32'd1);
    checkOutput("t2 inst_valid early", 32'(inst_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0020_8113, 2'b00, 1'b0);
    step();
    checkOutput("t2 inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("t2 inst", inst, 32'h0020_8113);
    checkOutput("t2 inst_pc", inst_pc, 32'h8000_0004);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    step();

    $display("[TB] SLVERR response");
    applyStimulus(1'b1, 32'h8000_0008, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_valid = 1'b0;
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 2'b10, 1'b0);
    step();
    checkOutput("t3 inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("t3 inst nop", inst, 32'h0000_0013);
    checkOutput("t3 fault", 32'(inst_fault), 32'd1);
    checkOutput("t3 inst_pc", inst_pc, 32'h8000_0008);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    step();

    $display("[TB] misaligned PC");
    applyStimulus(1'b1, 32'h8000_0002, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_valid = 1'b0;
    checkOutput("t4 inst_valid@1", 32'(inst_valid), 32'd1);
    checkOutput("t4 no arvalid", 32'(arvalid), 32'd0);
    checkOutput("t4 fault", 32'(inst_fault), 32'd1);
    checkOutput("t4 inst nop", inst, 32'h0000_0013);
    checkOutput("t4 inst_pc", inst_pc, 32'h8000_0002);
    step();
    checkOutput("t4 still no arvalid", 32'(arvalid), 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    $display("[TB] decode back-pressure");
    applyStimulus(1'b1, 32'h8000_000C, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_valid = 1'b0;
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h00a0_0513, 2'b00, 1'b0);
    step();
    applyStimulus(1'b1, 32'h8000_0010, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("t5 inst_valid %0d", i), 32'(inst_valid), 32'd1);
      checkOutput($sformatf("t5 inst %0d", i), inst, 32'h00a0_0513);
      checkOutput($sformatf("t5 inst_pc %0d", i), inst_pc, 32'h8000_000C);
      checkOutput($sformatf("t5 fault %0d", i), 32'(inst_fault), 32'd0);
      checkOutput($sformatf("t5 pc_ready %0d", i), 32'(pc_ready), 32'd0);
      checkOutput($sformatf("t5 no ar %0d", i), 32'(arvalid), 32'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checkOutput("t5 released", 32'(inst_valid), 32'd0);
    checkOutput("t5 pc_ready", 32'(pc_ready), 32'd1);
    step();
    pc_valid = 1'b0;
    checkOutput("t5 next arvalid", 32'(arvalid), 32'd1);
    checkOutput("t5 next araddr", araddr, 32'h8000_0010);

    $display("[TB] reset during DATA");
    step();
    checkOutput("t6 in DATA", 32'(rready), 32'd1);
    rst_n  = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hFFFF_FFFF;
    step();
    checkReset("t6 reset");
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h8000_0020, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0);
    step();
    pc_valid = 1'b0;
    checkOutput("t6 fresh araddr", araddr, 32'h8000_0020);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0030_0193, 2'b00, 1'b0);
    step();
    checkOutput("t6 fresh inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("t6 fresh inst", inst, 32'h0030_0193);
    checkOutput("t6 fresh inst_pc", inst_pc, 32'h8000_0020);
    checkOutput("t6 fresh fault", 32'(inst_fault), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    step();
    checkOutput("t6 final idle", 32'(pc_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
